spgd_metric_seq: RTL and testbench
==================================

Name: spgd_metric_seq

Overview:
Downstream of the calibrated ADC stage. Sequences one SPGD metric measurement pair:
- applies the + perturbation, waits for the mirrors to settle, then enables the ADC;
- captures the calibrated metric J+ when the ADC acquisition completes;
- repeats for the − perturbation to capture J−;
- emits dJ = J+ − J− with a one-cycle valid pulse for the gradient-update stage.

Parameters:
FP_WIDTH, 64, width of the calibrated metric and of dJ (same signed fixed-point format as the ADC calibrated output)
SETTLE_CYCLES, 16, cycles between a PERT_SIGN change and ADC_EN assertion; 0 means no settle
TIMEOUT_CYCLES, 65535, maximum cycles in an acquire state waiting for ADC_DONE
CNT_WIDTH, 16, counter width; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES)

Ports:
ADC_CLK  in  1  sole clock
REG_RST  in  1  synchronous, active-high reset
START  in  1  request one measurement pair; sampled only in IDLE
ADC_DONE  in  1  completion flag from the ADC stage (level)
ADC_CAL_OUT  in  FP_WIDTH  calibrated metric from the ADC stage
ADC_EN  out  1  enable to the ADC stage
PERT_SIGN  out  1  0 = + perturbation, 1 = − perturbation
J_PLUS  out  FP_WIDTH  last captured J+
J_MINUS  out  FP_WIDTH  last captured J−
DJ_OUT  out  FP_WIDTH  J_PLUS − J_MINUS
DJ_VALID  out  1  one-cycle pulse when DJ_OUT updates
BUSY  out  1  high in every state except IDLE
ERR  out  1  one-cycle pulse on acquire timeout

Behaviour:
- Reset (REG_RST high at a clock edge):
  - state goes to IDLE;
  - all outputs and counters go to 0, including the ADC_DONE history register done_q.
  - Reset mid-operation aborts immediately; ADC_EN is low the next cycle; no DJ_VALID or ERR is emitted.
- Edge detect: done_q <= ADC_DONE every cycle. done_rise = ADC_DONE & ~done_q.
  - Only a rising edge counts. A level held high from a previous acquisition is ignored until it falls and rises again.
- States and transitions:
  - IDLE: START=1 → SET_P. PERT_SIGN=0, count cleared. Register outputs hold their last values.
  - SET_P: PERT_SIGN=0. Stays SETTLE_CYCLES cycles (count 0..SETTLE_CYCLES−1), then → ACQ_P. With SETTLE_CYCLES=0, IDLE goes directly to ACQ_P.
  - ACQ_P: ADC_EN=1; count reset on entry.
    - done_rise → CAP_P.
    - count reaching TIMEOUT_CYCLES−1 without done_rise → IDLE with ERR=1 for one cycle.
    - done_rise in the final timeout cycle wins over the timeout.
  - CAP_P: ADC_EN=0. J_PLUS <= ADC_CAL_OUT. This gives one cycle of margin after DONE for the ADC output register. → SET_M.
  - SET_M, ACQ_M, CAP_M: identical to the + states with PERT_SIGN=1; CAP_M captures J_MINUS. CAP_M → DIFF.
  - DIFF: DJ_OUT <= J_PLUS − J_MINUS; DJ_VALID=1 for this cycle only; → IDLE. PERT_SIGN returns to 0 in IDLE.
- ADC_EN is a registered output: high exactly while in ACQ_P/ACQ_M, low otherwise.
- Arithmetic:
  - Subtraction is two's complement, modulo 2^FP_WIDTH; no saturation.
  - The binary point is unchanged from the input format.
- START:
  - ignored while BUSY;
  - START held high re-arms the sequence in the cycle after returning to IDLE.
- Latency:
  - START to DJ_VALID = 2·SETTLE_CYCLES + (cycles until each done_rise) + 6, counting the IDLE→first state cycle.
  - Minimum 6 cycles with SETTLE_CYCLES=0 and done_rise on the first ACQ cycle.
- ERR and DJ_VALID are never high in the same cycle.

Decomposition:
- Shared package: state encoding constants (IDLE, SET_P, ACQ_P, CAP_P, SET_M, ACQ_M, CAP_M, DIFF), PERT_PLUS/PERT_MINUS constants.
- Subtraction reuses the existing generic subtractor used in the ADC calibration path.
- One natural sub-module: spgd_settle_timer. It is a loadable down-counter with an expiry flag, used both for settle and for timeout.

Test Plan:
- SETTLE_CYCLES=4. START pulse; ADC_DONE rises 10 cycles into ACQ_P with ADC_CAL_OUT=0x0000_0010_0000_0000; repeat in ACQ_M with 0x0000_0004_0000_0000 → J_PLUS and J_MINUS hold those values; DJ_OUT=0x0000_000C_0000_0000; DJ_VALID high exactly 1 cycle; ADC_EN first rises 5 cycles after START.
- Negative result: J+=0x...04_0000_0000, J−=0x...10_0000_0000 → DJ_OUT=0xFFFF_FFF4_0000_0000.
- ADC_DONE held high entering ACQ_P → no capture until DONE falls and rises again.
- TIMEOUT_CYCLES=8, no ADC_DONE → ERR pulse on the 8th ACQ_P cycle; state returns to IDLE; ADC_EN=0; DJ_VALID never asserted; DJ_OUT unchanged.
- REG_RST asserted during ACQ_M → next cycle: all outputs 0, BUSY=0. A later START runs a full clean pair.
- START pulsed during SET_M → ignored; exactly one DJ_VALID produced. START held high continuously → back-to-back pairs, one DJ_VALID per pair.

Source files
------------

// File: rtl/spgd_metric_seq_pkg.sv
// rtl/spgd_metric_seq_pkg.sv - state encoding and perturbation constants for the SPGD metric sequencer
package spgd_metric_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET_P = 3'd1,
      ST_ACQ_P = 3'd2,
      ST_CAP_P = 3'd3,
      ST_SET_M = 3'd4,
      ST_ACQ_M = 3'd5,
      ST_CAP_M = 3'd6,
      ST_DIFF  = 3'd7
   } state_t;

   localparam logic PERT_PLUS  = 1'b0;
   localparam logic PERT_MINUS = 1'b1;

   function automatic logic is_acq(input state_t s);
      return (s == ST_ACQ_P) || (s == ST_ACQ_M);
   endfunction

   // DIFF keeps the minus sign; the mirrors return to + only once back in IDLE
   function automatic logic is_minus(input state_t s);
      return s inside {ST_SET_M, ST_ACQ_M, ST_CAP_M, ST_DIFF};
   endfunction

endpackage

// File: rtl/fp_sub.sv
// rtl/fp_sub.sv - generic two's-complement subtractor, wraps modulo 2^WIDTH
module fp_sub #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff
);

   assign diff = a - b;

endmodule

// File: rtl/spgd_settle_timer.sv
// rtl/spgd_settle_timer.sv - loadable down-counter with expiry flag, shared by settle and timeout
module spgd_settle_timer #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   output logic                 expired
);

   logic [CNT_WIDTH-1:0] count;

   // Holds at zero so expiry stays asserted until the next load
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_WIDTH'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/spgd_metric_seq.sv
// rtl/spgd_metric_seq.sv - sequences one +/- perturbation metric pair and emits dJ = J+ - J-
module spgd_metric_seq
   import spgd_metric_seq_pkg::*;
#(
   parameter int FP_WIDTH       = 64,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                ADC_CLK,
   input  logic                REG_RST,
   input  logic                START,
   input  logic                ADC_DONE,
   input  logic [FP_WIDTH-1:0] ADC_CAL_OUT,
   output logic                ADC_EN,
   output logic                PERT_SIGN,
   output logic [FP_WIDTH-1:0] J_PLUS,
   output logic [FP_WIDTH-1:0] J_MINUS,
   output logic [FP_WIDTH-1:0] DJ_OUT,
   output logic                DJ_VALID,
   output logic                BUSY,
   output logic                ERR
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD  =
      CNT_WIDTH'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   // Zero settle skips the SET states entirely and arms the timeout directly
   localparam state_t                FIRST_P    = (SETTLE_CYCLES == 0) ? ST_ACQ_P : ST_SET_P;
   localparam state_t                FIRST_M    = (SETTLE_CYCLES == 0) ? ST_ACQ_M : ST_SET_M;
   localparam logic [CNT_WIDTH-1:0]  FIRST_LOAD = (SETTLE_CYCLES == 0) ? TIMEOUT_LOAD : SETTLE_LOAD;

   state_t                state;
   state_t                state_n;
   logic                  done_q;
   logic                  done_rise;
   logic                  tmr_load;
   logic [CNT_WIDTH-1:0]  tmr_val;
   logic                  tmr_expired;
   logic                  cap_p;
   logic                  cap_m;
   logic                  do_diff;
   logic                  timeout;
   logic [FP_WIDTH-1:0]   diff;

   assign done_rise = ADC_DONE & ~done_q;

   spgd_settle_timer #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_timer (
      .clk      (ADC_CLK),
      .rst      (REG_RST),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   fp_sub #(
      .WIDTH(FP_WIDTH)
   ) u_sub (
      .a    (J_PLUS),
      .b    (J_MINUS),
      .diff (diff)
   );

   always_comb begin
      state_n  = state;
      tmr_load = 1'b0;
      tmr_val  = TIMEOUT_LOAD;
      cap_p    = 1'b0;
      cap_m    = 1'b0;
      do_diff  = 1'b0;
      timeout  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) begin
               state_n  = FIRST_P;
               tmr_load = 1'b1;
               tmr_val  = FIRST_LOAD;
            end
         end
         ST_SET_P: begin
            if (tmr_expired) begin
               state_n  = ST_ACQ_P;
               tmr_load = 1'b1;
            end
         end
         ST_ACQ_P: begin
            if (done_rise) begin
               state_n = ST_CAP_P;
            end else if (tmr_expired) begin
               state_n = ST_IDLE;
               timeout = 1'b1;
            end
         end
         ST_CAP_P: begin
            cap_p    = 1'b1;
            state_n  = FIRST_M;
            tmr_load = 1'b1;
            tmr_val  = FIRST_LOAD;
         end
         ST_SET_M: begin
            if (tmr_expired) begin
               state_n  = ST_ACQ_M;
               tmr_load = 1'b1;
            end
         end
         ST_ACQ_M: begin
            if (done_rise) begin
               state_n = ST_CAP_M;
            end else if (tmr_expired) begin
               state_n = ST_IDLE;
               timeout = 1'b1;
            end
         end
         ST_CAP_M: begin
            cap_m   = 1'b1;
            state_n = ST_DIFF;
         end
         ST_DIFF: begin
            do_diff = 1'b1;
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register
   always_ff @(posedge ADC_CLK) begin
      if (REG_RST) begin
         state     <= ST_IDLE;
         done_q    <= 1'b0;
         ADC_EN    <= 1'b0;
         PERT_SIGN <= PERT_PLUS;
         BUSY      <= 1'b0;
         J_PLUS    <= '0;
         J_MINUS   <= '0;
         DJ_OUT    <= '0;
         DJ_VALID  <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         state     <= state_n;
         done_q    <= ADC_DONE;
         ADC_EN    <= is_acq(state_n);
         PERT_SIGN <= is_minus(state_n) ? PERT_MINUS : PERT_PLUS;
         BUSY      <= (state_n != ST_IDLE);
         DJ_VALID  <= do_diff;
         ERR       <= timeout;
         if (cap_p) begin
            J_PLUS <= ADC_CAL_OUT;
         end
         if (cap_m) begin
            J_MINUS <= ADC_CAL_OUT;
         end
         if (do_diff) begin
            DJ_OUT <= diff;
         end
      end
   end

endmodule

// File: tb/tb_spgd_metric_seq.sv
// tb/tb_spgd_metric_seq.sv - scoreboard bench for spgd_metric_seq (settle=4 and settle=0/timeout=8 instances)
module tb_spgd_metric_seq;

   typedef struct packed {
      logic [63:0] jp;
      logic [63:0] jm;
      logic [63:0] dj;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start_a, done_a, en_a, sign_a, dv_a, busy_a, err_a;
   logic [63:0] cal_a, jp_a, jm_a, dj_a;
   logic        start_b, done_b, en_b, sign_b, dv_b, busy_b, err_b;
   logic [63:0] cal_b, jp_b, jm_b, dj_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   err_exp_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e;
   logic dv_prev_a = 1'b0;
   logic dv_prev_b = 1'b0;

   spgd_metric_seq #(
      .FP_WIDTH(64), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(32), .CNT_WIDTH(16)
   ) u_a (
      .ADC_CLK(clk), .REG_RST(rst), .START(start_a), .ADC_DONE(done_a), .ADC_CAL_OUT(cal_a),
      .ADC_EN(en_a), .PERT_SIGN(sign_a), .J_PLUS(jp_a), .J_MINUS(jm_a), .DJ_OUT(dj_a),
      .DJ_VALID(dv_a), .BUSY(busy_a), .ERR(err_a)
   );

   spgd_metric_seq #(
      .FP_WIDTH(64), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)
   ) u_b (
      .ADC_CLK(clk), .REG_RST(rst), .START(start_b), .ADC_DONE(done_b), .ADC_CAL_OUT(cal_b),
      .ADC_EN(en_b), .PERT_SIGN(sign_b), .J_PLUS(jp_b), .J_MINUS(jm_b), .DJ_OUT(dj_b),
      .DJ_VALID(dv_b), .BUSY(busy_b), .ERR(err_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit reached, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a DUT presents DJ_VALID
   always @(negedge clk) begin
      if (dv_a || err_a) check("a err and dj_valid together", dv_a & err_a, 1'b0);
      if (dv_a) begin
         check("a dj_valid one cycle", dv_prev_a, 1'b0);
         if (q_a.size() == 0) begin
            check("a stray dj_valid", dv_a, 1'b0);
         end else begin
            e = q_a.pop_front();
            check("a dj_out", dj_a, e.dj);
            check("a j_plus", jp_a, e.jp);
            check("a j_minus", jm_a, e.jm);
         end
      end
      if (err_a) check("a stray err", err_a, 1'b0);
      if (dv_b || err_b) check("b err and dj_valid together", dv_b & err_b, 1'b0);
      if (dv_b) begin
         check("b dj_valid one cycle", dv_prev_b, 1'b0);
         if (q_b.size() == 0) begin
            check("b stray dj_valid", dv_b, 1'b0);
         end else begin
            e = q_b.pop_front();
            check("b dj_out", dj_b, e.dj);
            check("b j_plus", jp_b, e.jp);
            check("b j_minus", jm_b, e.jm);
         end
      end
      if (err_b) begin
         check("b err expected", (err_exp_b > 0), 1'b1);
         if (err_exp_b > 0) err_exp_b--;
      end
      dv_prev_a = dv_a;
      dv_prev_b = dv_b;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input bit b, input logic v);
      if (b) start_b = v; else start_a = v;
   endtask

   task automatic set_done(input bit b, input logic v);
      if (b) done_b = v; else done_a = v;
   endtask

   task automatic set_cal(input bit b, input logic [63:0] v);
      if (b) cal_b = v; else cal_a = v;
   endtask

   function automatic logic cur_en(input bit b);
      return b ? en_b : en_a;
   endfunction

   task automatic wait_en(input bit b, input logic v);
      int n = 0;
      while (cur_en(b) !== v && n < 200) begin
         tick;
         n++;
      end
      check("wait for adc_en level", cur_en(b), v);
   endtask

   task automatic drain(input bit b);
      int n = 0;
      while (((b ? q_b.size() : q_a.size()) != 0 || (b ? busy_b : busy_a)) && n < 400) begin
         tick;
         n++;
      end
      check("drain within budget", (n < 400), 1'b1);
   endtask

   task automatic pulse_start(input bit b);
      set_start(b, 1'b1);
      tick;
      set_start(b, 1'b0);
   endtask

   // Answers one measurement pair: DONE rises on cycle wp of ACQ_P and cycle wm of ACQ_M
   task automatic acquire_pair(input bit b, input logic [63:0] jp, input logic [63:0] jm,
                               input int wp, input int wm, input bit held,
                               input bit drop_start, input bit poke);
      wait_en(b, 1'b1);
      if (drop_start) set_start(b, 1'b0);
      if (held) begin
         repeat (5) tick;
         check("held done no capture", cur_en(b), 1'b1);
         set_done(b, 1'b0);
      end
      repeat (wp - 1) tick;
      set_cal(b, jp);
      set_done(b, 1'b1);
      wait_en(b, 1'b0);
      tick;
      set_done(b, 1'b0);
      if (poke) pulse_start(b);
      wait_en(b, 1'b1);
      repeat (wm - 1) tick;
      set_cal(b, jm);
      set_done(b, 1'b1);
      wait_en(b, 1'b0);
      tick;
      set_done(b, 1'b0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start_a = 1'b0; done_a = 1'b0; cal_a = '0;
      start_b = 1'b0; done_b = 1'b0; cal_b = '0;
      repeat (3) tick;
      check("reset adc_en", en_a, 1'b0);
      check("reset busy", busy_a, 1'b0);
      check("reset dj_out", dj_a, 64'h0);
      check("reset pert_sign", sign_b, 1'b0);
      rst = 1'b0;
      tick;

      // Basic pair with start-to-ADC_EN latency
      q_a.push_back('{64'h0000_0010_0000_0000, 64'h0000_0004_0000_0000, 64'h0000_000C_0000_0000});
      set_start(0, 1'b1);
      tick;
      set_start(0, 1'b0);
      n = 1;
      while (!en_a && n < 50) begin
         tick;
         n++;
      end
      check("a start to adc_en cycles", n, 5);
      check("a pert_sign plus in acq_p", sign_a, 1'b0);
      acquire_pair(0, 64'h0000_0010_0000_0000, 64'h0000_0004_0000_0000, 10, 10, 0, 0, 0);
      drain(0);
      check("a j_plus holds", jp_a, 64'h0000_0010_0000_0000);
      check("a j_minus holds", jm_a, 64'h0000_0004_0000_0000);

      // Negative difference
      q_a.push_back('{64'h0000_0004_0000_0000, 64'h0000_0010_0000_0000, 64'hFFFF_FFF4_0000_0000});
      pulse_start(0);
      acquire_pair(0, 64'h0000_0004_0000_0000, 64'h0000_0010_0000_0000, 2, 3, 0, 0, 0);
      drain(0);

      // DONE already high when ACQ_P is entered
      set_done(0, 1'b1);
      q_a.push_back('{64'h0000_0000_0000_0123, 64'h0000_0000_0000_0023, 64'h0000_0000_0000_0100});
      pulse_start(0);
      acquire_pair(0, 64'h0000_0000_0000_0123, 64'h0000_0000_0000_0023, 3, 2, 1, 0, 0);
      drain(0);

      // Reset during ACQ_M aborts the pair
      pulse_start(0);
      wait_en(0, 1'b1);
      set_cal(0, 64'h0000_0000_0000_0AAA);
      set_done(0, 1'b1);
      wait_en(0, 1'b0);
      tick;
      set_done(0, 1'b0);
      wait_en(0, 1'b1);
      check("a in acq_m before reset", sign_a, 1'b1);
      repeat (3) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort adc_en", en_a, 1'b0);
      check("abort busy", busy_a, 1'b0);
      check("abort pert_sign", sign_a, 1'b0);
      check("abort j_plus", jp_a, 64'h0);
      check("abort dj_out", dj_a, 64'h0);
      check("abort dj_valid", dv_a, 1'b0);
      check("abort err", err_a, 1'b0);
      q_a.push_back('{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF});
      pulse_start(0);
      acquire_pair(0, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 4, 4, 0, 0, 0);
      drain(0);

      // START pulsed during SET_M is ignored
      q_a.push_back('{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 64'h0});
      pulse_start(0);
      acquire_pair(0, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 2, 2, 0, 0, 1);
      drain(0);
      repeat (40) tick;
      check("a idle after ignored start", busy_a, 1'b0);

      // START held high: back-to-back pairs
      q_a.push_back('{64'h0000_0000_0001_0000, 64'h0000_0000_0002_0000, 64'hFFFF_FFFF_FFFF_0000});
      q_a.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
      set_start(0, 1'b1);
      acquire_pair(0, 64'h0000_0000_0001_0000, 64'h0000_0000_0002_0000, 2, 2, 0, 0, 0);
      acquire_pair(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2, 2, 0, 1, 0);
      drain(0);
      repeat (40) tick;
      check("a idle after held start released", busy_a, 1'b0);

      // Zero settle, DONE on first ACQ cycle: minimum latency of 6
      q_b.push_back('{64'h0000_0000_0000_0007, 64'h0000_0000_0000_0009, 64'hFFFF_FFFF_FFFF_FFFE});
      set_start(1, 1'b1);
      tick;
      set_start(1, 1'b0);
      set_cal(1, 64'h0000_0000_0000_0007);
      set_done(1, 1'b1);
      tick;
      set_done(1, 1'b0);
      tick;
      set_cal(1, 64'h0000_0000_0000_0009);
      set_done(1, 1'b1);
      tick;
      tick;
      set_done(1, 1'b0);
      check("b dj_valid before min latency", dv_b, 1'b0);
      tick;
      check("b dj_valid at min latency", dv_b, 1'b1);
      drain(1);

      // Timeout with no DONE
      err_exp_b = 1;
      pulse_start(1);
      n = 0;
      while (en_b && n < 50) begin
         n++;
         tick;
      end
      check("b acq cycles before timeout", n, 8);
      check("b err pulse", err_b, 1'b1);
      check("b busy after timeout", busy_b, 1'b0);
      check("b dj_out unchanged", dj_b, 64'hFFFF_FFFF_FFFF_FFFE);
      tick;
      check("b err one cycle", err_b, 1'b0);

      // DONE rising in the final timeout cycle wins
      q_b.push_back('{64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_00FF});
      pulse_start(1);
      acquire_pair(1, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 8, 2, 0, 0, 0);
      drain(1);
      repeat (5) tick;

      check("a scoreboard empty", q_a.size(), 0);
      check("b scoreboard empty", q_b.size(), 0);
      check("b expected err consumed", err_exp_b, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
